axis_rr_sched: RTL and testbench
================================

# axis_rr_sched

Round-robin scheduler that shares one single-beat AXI-Stream master port among `NREQ` local requesters. Each requester presents a 32-bit word and a level request. The block grants one requester at a time, launches its word as a one-beat packet (`tlast` with every beat), waits for the slave handshake, then reports completion to that requester. It sits between user-side producers and the AXI-Stream link, replacing per-producer stream masters.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `IW`, 2: width of `tdest`; must satisfy 2^IW >= NREQ.

Ports:
- `aclk`, in, 1: clock. All logic is rising-edge.
- `areset_n`, in, 1: reset, synchronous, active-low.
- `req`, in, NREQ: per-requester level request; bit i high means word i is pending.
- `req_data`, in, 32*NREQ: requester i word in bits [32*i+31 : 32*i]; must be stable while `req[i]` is high.
- `ack`, out, NREQ: one-cycle pulse; the word of requester i has been captured.
- `done`, out, NREQ: one-cycle pulse; the beat of requester i has been accepted by the slave.
- `busy`, out, 1: high in the SEND state.
- `tready`, in, 1: AXIS slave ready.
- `tvalid`, out, 1: AXIS valid, registered.
- `tlast`, out, 1: always equal to `tvalid`.
- `tdata`, out, 32: AXIS data, registered.
- `tdest`, out, IW: index of the granted requester, registered.

## Operation
- **Reset** (`areset_n` = 0 at an edge), applied in any state:
  - `tvalid`, `tdata`, `tdest`, `ack`, `done`, `busy` go to 0.
  - Round-robin pointer `ptr` goes to 0.
  - FSM goes to IDLE.
  - An in-flight beat is dropped with no `done`.
- **FSM states:** IDLE and SEND.
- **IDLE:**
  - If `req` == 0, stay in IDLE. `ack` and `done` are 0.
  - Otherwise select `g`, the first set bit of `req` searching circularly from `ptr` upward (`ptr`, `ptr`+1, … NREQ-1, 0, …).
  - At the edge: `tdata` <= word g, `tdest` <= g, `tvalid` <= 1, `ack[g]` <= 1 for one cycle, `busy` <= 1, go to SEND.
- **SEND:**
  - `tvalid`, `tdata`, `tdest` are held constant until handshake (`tvalid & tready`).
  - At the handshake edge: `tvalid` <= 0, `done[g]` <= 1 for one cycle, `ptr` <= (g+1) mod NREQ (wraps from NREQ-1 to 0), `busy` <= 0, go to IDLE.
  - `tdata` and `tdest` keep their last values after the handshake.
  - `req` is ignored in SEND.
- **Request rules:**
  - A requester must lower `req[i]` in the cycle after seeing `ack[i]` to avoid re-arbitration.
  - A `req[i]` still high when the FSM returns to IDLE is a new request, arbitrated normally. Because `ptr` has advanced past i, other pending requesters win first.
  - A `req[i]` dropped before it is granted is silently withdrawn.
- **Pointer rule:** `ptr` changes only on a handshake, never on a grant alone.
- **Arithmetic:** pointer increment is modulo NREQ, not modulo 2^IW.

## Timing
- **Grant latency:** `req[i]` sampled high in IDLE at edge k gives `tvalid`, `tdata`, `tdest` and `ack[i]` valid after edge k.
- **Stall:** while `tready` = 0, the outputs stay frozen for any number of cycles.
- **Completion:**
  - If `tready` is already 1 when `tvalid` rises, the handshake occurs at edge k+1; `done[i]` is high for the cycle after k+1 and `tvalid` is low after k+1.
  - Handshake at edge h gives `done` high during cycle h+1 only.
- **Throughput:** at most one beat per 2 cycles. IDLE always lasts at least one cycle between beats, so `tvalid` is low for at least one cycle between packets.
- **Pulse overlap:** `ack` and `done` are never high together for the same requester. A `done[i]` pulse and an `ack[j]` pulse never overlap, since the next `ack` follows a full IDLE cycle.
- **Simultaneous events:** a reset edge coinciding with a handshake edge takes reset; no `done` is produced.
- **`tready` outside a transfer:** `tready` while `tvalid` = 0 has no effect.

## Test plan
- **Reset values:** hold `areset_n` = 0 for 3 cycles with `req` = 4'b1111 and `tready` = 1 -> all outputs 0 throughout; first grant after release goes to requester 0.
- **Single request, zero wait:** `req` = 4'b0100, word 2 = 32'hA5A5_0002, `tready` = 1 -> `tvalid`, `ack[2]`, `tdata` = 32'hA5A5_0002 and `tdest` = 2 one cycle after the request; `done[2]` the following cycle; `tvalid` high for exactly 1 cycle.
- **Backpressure:** same request with `tready` = 0 for 5 cycles, then 1 -> `tvalid`, `tlast`, `tdata`, `tdest` constant for 6 cycles; exactly one `done[2]` pulse, one cycle after the handshake.
- **Fairness and wrap-around:** `req` = 4'b1111 held (each requester drops its bit after its `ack`, then re-raises it), `tready` = 1 -> grant order 0,1,2,3,0,1; `tdest` sequence matches; `tvalid` low exactly 1 cycle between beats.
- **Pointer skip:** after serving requester 2, assert `req` = 4'b0011 -> requester 0 is granted (search 3 → 0), then requester 1.
- **Reset mid-transfer:** grant requester 1, hold `tready` = 0, assert reset at the 3rd stall cycle -> `tvalid` = 0 after that edge, no `done[1]`, `ptr` = 0; re-request `req` = 4'b0010 -> normal grant to 1.

Source files
------------

// File: rtl/axis_rr_sched.sv
// axis_rr_sched: round-robin scheduler sharing one single-beat AXI-Stream master among NREQ requesters
module axis_rr_sched #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic              aclk,
  input  logic              areset_n,
  input  logic [NREQ-1:0]   req,
  input  logic [32*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  input  logic              tready,
  output logic              tvalid,
  output logic              tlast,
  output logic [31:0]       tdata,
  output logic [IW-1:0]     tdest
);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_nxt;
  logic [IW-1:0]     ptr, g;
  logic [2*NREQ-1:0] rot;
  logic [IW:0]       off, sum;
  logic [31:0]       words [NREQ];
  for (genvar i = 0; i < NREQ; i++) begin : g_words
    assign words[i] = req_data[32*i +: 32];
  end
  // Rotate so bit 0 is the requester at ptr; the lowest set bit is the winner offset.
  always_comb begin
    rot = {req, req} >> ptr;
    off = '0;
    for (int k = NREQ-1; k >= 0; k--) off = rot[k] ? (IW+1)'(k) : off;
    sum = {1'b0, ptr} + off;
    g = sum >= (IW+1)'(NREQ) ? IW'(sum - (IW+1)'(NREQ)) : sum[IW-1:0];
  end
  always_comb state_nxt = state == IDLE ? (|req ? SEND : IDLE) : (tready ? IDLE : SEND);
  assign busy  = state == SEND;
  assign tlast = tvalid;
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      state  <= IDLE;
      ptr    <= '0;
      tvalid <= 1'b0;
      tdata  <= '0;
      tdest  <= '0;
      ack    <= '0;
      done   <= '0;
    end else begin
      state <= state_nxt;
      ack   <= '0;
      done  <= '0;
      if (state == IDLE && |req) begin
        tvalid <= 1'b1;
        tdata  <= words[g];
        tdest  <= g;
        ack    <= NREQ'(1) << g;
      end
      if (state == SEND && tready) begin
        tvalid <= 1'b0;
        done   <= NREQ'(1) << tdest;
        ptr    <= tdest == IW'(NREQ-1) ? '0 : tdest + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_axis_rr_sched.sv
// tb_axis_rr_sched: vector table, corner sequences and random traffic against a circular-search reference model
module tb_axis_rr_sched;
  localparam int N = 4, IW = 2;
  logic aclk = 1'b0, areset_n = 1'b0, tready = 1'b0;
  logic [N-1:0] req = '0;
  logic [32*N-1:0] req_data;
  logic [N-1:0] ack, done;
  logic busy, tvalid, tlast;
  logic [31:0] tdata;
  logic [IW-1:0] tdest;
  logic [31:0] words [N];
  int errors = 0, checks = 0;
  bit m_send;
  int m_ptr;
  logic m_valid;
  logic [31:0] m_data;
  logic [IW-1:0] m_dest;
  logic [N-1:0] m_ack, m_done;

  typedef struct packed {
    logic rst_n; logic [N-1:0] req; logic tready;
    logic tvalid; logic [N-1:0] ack; logic [N-1:0] done; logic [IW-1:0] tdest;
  } vec_t;
  vec_t tbl [13];

  always #5 aclk = ~aclk;
  always_comb for (int i = 0; i < N; i++) req_data[32*i +: 32] = words[i];

  axis_rr_sched #(.NREQ(N), .IW(IW)) dut (
    .aclk(aclk), .areset_n(areset_n), .req(req), .req_data(req_data),
    .ack(ack), .done(done), .busy(busy), .tready(tready),
    .tvalid(tvalid), .tlast(tlast), .tdata(tdata), .tdest(tdest)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: first pending requester found by walking ptr, ptr+1, ... modulo N.
  task automatic model_step();
    if (!areset_n) begin
      m_send = 0; m_ptr = 0; m_valid = 0; m_data = '0; m_dest = '0; m_ack = '0; m_done = '0;
    end else begin
      m_ack = '0; m_done = '0;
      if (!m_send) begin
        for (int n = 0; n < N; n++) begin
          int i;
          i = (m_ptr + n) % N;
          if (req[i] && !m_send) begin
            m_send = 1; m_valid = 1; m_data = words[i]; m_dest = IW'(i); m_ack[i] = 1'b1;
          end
        end
      end else if (tready) begin
        m_valid = 0; m_done[m_dest] = 1'b1; m_ptr = (int'(m_dest) + 1) % N; m_send = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    model_step();
    #1;
    check("model", {busy, tvalid, tlast, ack, done, tdest, tdata},
          {m_send, m_valid, m_valid, m_ack, m_done, m_dest, m_data});
  endtask

  initial begin
    int hi, dn, lowrun, gap_bad, idx;
    bit seen;
    logic [31:0] d0;
    logic [N-1:0] p;
    int order [$];
    for (int i = 0; i < N; i++) words[i] = 32'hA5A5_0000 | 32'(i);
    tbl[0]  = '{1'b0, 4'b1111, 1'b1, 1'b0, 4'b0000, 4'b0000, 2'd0};
    tbl[1]  = '{1'b0, 4'b1111, 1'b1, 1'b0, 4'b0000, 4'b0000, 2'd0};
    tbl[2]  = '{1'b0, 4'b1111, 1'b1, 1'b0, 4'b0000, 4'b0000, 2'd0};
    tbl[3]  = '{1'b1, 4'b0001, 1'b1, 1'b1, 4'b0001, 4'b0000, 2'd0};
    tbl[4]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0001, 2'd0};
    tbl[5]  = '{1'b1, 4'b0100, 1'b1, 1'b1, 4'b0100, 4'b0000, 2'd2};
    tbl[6]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0100, 2'd2};
    tbl[7]  = '{1'b1, 4'b0011, 1'b1, 1'b1, 4'b0001, 4'b0000, 2'd0};
    tbl[8]  = '{1'b1, 4'b0010, 1'b1, 1'b0, 4'b0000, 4'b0001, 2'd0};
    tbl[9]  = '{1'b1, 4'b0010, 1'b1, 1'b1, 4'b0010, 4'b0000, 2'd1};
    tbl[10] = '{1'b1, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0000, 2'd1};
    tbl[11] = '{1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0010, 2'd1};
    tbl[12] = '{1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 2'd1};
    for (int r = 0; r < 13; r++) begin
      areset_n = tbl[r].rst_n; req = tbl[r].req; tready = tbl[r].tready;
      tick();
      check($sformatf("vec%0d", r), {tvalid, tlast, busy, ack, done, tdest},
            {tbl[r].tvalid, tbl[r].tvalid, tbl[r].tvalid, tbl[r].ack, tbl[r].done, tbl[r].tdest});
    end
    // Backpressure on requester 2: six frozen cycles, one done pulse.
    req = 4'b0100; tready = 1'b0; hi = 0; dn = 0;
    tick();
    d0 = tdata;
    hi += int'(tvalid);
    req = '0;
    for (int s = 0; s < 5; s++) begin
      tick();
      hi += int'(tvalid && tlast && tdata == d0 && tdest == 2'd2);
      dn += int'(done[2]);
    end
    tready = 1'b1;
    tick(); dn += int'(done[2]); hi += int'(tvalid);
    tick(); dn += int'(done[2]);
    check("bp_hold", hi, 6);
    check("bp_done", dn, 1);
    // Fairness with requesters re-raising after their done.
    areset_n = 1'b0; tick(); tick(); areset_n = 1'b1;
    p = 4'b1111; lowrun = 0; gap_bad = 0; seen = 0;
    for (int c = 0; c < 40 && order.size() < 6; c++) begin
      req = p;
      tick();
      if (tvalid && seen && lowrun != 1) gap_bad++;
      if (tvalid) begin seen = 1; lowrun = 0; end else lowrun++;
      idx = -1;
      for (int i = 0; i < N; i++) if (ack[i]) idx = i;
      if (idx >= 0) order.push_back(idx);
      p = (p & ~ack) | done;
    end
    check("fair_count", order.size(), 6);
    for (int k = 0; k < order.size(); k++) check($sformatf("fair_order%0d", k), order[k], k % N);
    check("fair_gap", gap_bad, 0);
    req = '0; tick();
    // Reset during a stalled transfer drops the beat and clears the pointer.
    req = 4'b0010; tready = 1'b0;
    tick();
    check("mid_grant", {ack, tdest}, {4'b0010, 2'd1});
    req = '0; tick(); tick();
    areset_n = 1'b0; tick();
    check("mid_rst", {tvalid, busy, done}, '0);
    areset_n = 1'b1; req = 4'b0011;
    tick();
    check("mid_ptr0", {ack, tdest}, {4'b0001, 2'd0});
    req = 4'b0010; tready = 1'b1;
    tick(); tick();
    check("mid_regrant", {ack, tdest, tvalid}, {4'b0010, 2'd1, 1'b1});
    req = '0; tick(); tick();
    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      areset_n = ($urandom % 50) != 0;
      req = N'($urandom) & N'($urandom | $urandom);
      tready = ($urandom % 3) != 0;
      for (int i = 0; i < N; i++) if (!req[i]) words[i] = $urandom;
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
